// File: rtl/neo_strand_engine.sv
// WS2812 strand driver: double-buffered GRB pixel store, brightness scaling,
// single-shot or continuous refresh, with a frame-done pulse on the last latch cycle.
module neo_strand_engine #(
  parameter int unsigned NUM_PIXELS = 8,
  parameter int unsigned COLOR_W    = 8,
  parameter int unsigned BIT_CYC    = 63,
  parameter int unsigned T0H_CYC    = 18,
  parameter int unsigned T1H_CYC    = 35,
  parameter int unsigned LATCH_CYC  = 2500,
  parameter int unsigned IDX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [IDX_W-1:0]   pixel_index,
  input  logic [1:0]         color_index,
  input  logic [COLOR_W-1:0] color_level,
  input  logic               load_color,
  input  logic               send_it,
  input  logic               repeat_mode,
  input  logic [COLOR_W-1:0] brightness,
  output logic               neo_data,
  output logic               ready_to_load,
  output logic               ready_to_send,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned TOTAL_BITS = 3 * COLOR_W * NUM_PIXELS;
  localparam int unsigned CYC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int unsigned BIT_W = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
  localparam int unsigned LAT_W = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
  localparam int unsigned POS_W = (COLOR_W > 1) ? $clog2(COLOR_W) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);
  localparam logic [CYC_W-1:0] T0H      = CYC_W'(T0H_CYC);
  localparam logic [CYC_W-1:0] T1H      = CYC_W'(T1H_CYC);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL_BITS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYC - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(COLOR_W - 1);

  typedef enum logic [1:0] {StIdle, StSend, StLatch} state_e;

  state_e state_q, state_d;

  // Buffers indexed [pixel][color_index]: 0=R, 1=G, 2=B.
  logic [COLOR_W-1:0] back_q  [NUM_PIXELS][3];
  logic [COLOR_W-1:0] front_q [NUM_PIXELS][3];
  logic [COLOR_W-1:0] bright_q;

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [IDX_W-1:0] pix_q, pix_d;
  logic [1:0]       chan_q, chan_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             start;

  logic neo_q, busy_q, rts_q, rtl_q, done_q;

  logic               wr_en;
  logic [1:0]         col_sel;
  logic [COLOR_W-1:0] level;
  logic [COLOR_W:0]   scale;
  logic [2*COLOR_W:0] prod;
  logic [COLOR_W-1:0] scaled;
  logic               next_bit;
  logic [CYC_W-1:0]   high_len;

  assign wr_en = load_color && (color_index != 2'd3) && (32'(pixel_index) < NUM_PIXELS);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    lat_d   = lat_q;
    pix_d   = pix_q;
    chan_d  = chan_q;
    pos_d   = pos_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (send_it) start = 1'b1;
      end
      StSend: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = StLatch;
            lat_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
            if (pos_q == POS_LAST) begin
              pos_d = '0;
              if (chan_q == 2'd2) begin
                chan_d = 2'd0;
                pix_d  = pix_q + 1'b1;
              end else begin
                chan_d = chan_q + 1'b1;
              end
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StLatch: begin
        if (lat_q == LAT_LAST) begin
          if (repeat_mode) start = 1'b1;
          else             state_d = StIdle;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (start) begin
      state_d = StSend;
      cyc_d   = '0;
      bit_d   = '0;
      pix_d   = '0;
      chan_d  = 2'd0;
      pos_d   = '0;
    end
  end

  // Level of the bit that will be on the wire next cycle. On a frame start the
  // front buffer is stale, but the first cycle of any bit is high regardless.
  always_comb begin
    case (chan_d)
      2'd0:    col_sel = 2'd1;
      2'd1:    col_sel = 2'd0;
      default: col_sel = 2'd2;
    endcase
    level    = front_q[pix_d][col_sel];
    scale    = {1'b0, bright_q} + {{COLOR_W{1'b0}}, 1'b1};
    prod     = {{(COLOR_W + 1){1'b0}}, level} * {{COLOR_W{1'b0}}, scale};
    scaled   = prod[2*COLOR_W-1:COLOR_W];
    next_bit = scaled[POS_LAST - pos_d];
    high_len = next_bit ? T1H : T0H;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cyc_q    <= '0;
      bit_q    <= '0;
      lat_q    <= '0;
      pix_q    <= '0;
      chan_q   <= 2'd0;
      pos_q    <= '0;
      bright_q <= '0;
      neo_q    <= 1'b0;
      busy_q   <= 1'b0;
      rts_q    <= 1'b1;
      rtl_q    <= 1'b0;
      done_q   <= 1'b0;
      for (int p = 0; p < int'(NUM_PIXELS); p++) begin
        for (int c = 0; c < 3; c++) begin
          back_q[p][c]  <= '0;
          front_q[p][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      lat_q   <= lat_d;
      pix_q   <= pix_d;
      chan_q  <= chan_d;
      pos_q   <= pos_d;
      neo_q   <= (state_d == StSend) && (cyc_d < high_len);
      busy_q  <= (state_d != StIdle);
      rts_q   <= (state_d == StIdle);
      rtl_q   <= 1'b1;
      done_q  <= (state_d == StLatch) && (lat_d == LAT_LAST);
      if (start) begin
        front_q  <= back_q;
        bright_q <= brightness;
      end
      if (wr_en) back_q[pixel_index][color_index] <= color_level;
    end
  end

  assign neo_data      = neo_q;
  assign busy          = busy_q;
  assign ready_to_send = rts_q;
  assign ready_to_load = rtl_q;
  assign frame_done    = done_q;

endmodule
